uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller that sequences and configures the UART RX datapath and buffers its output. It owns the RX configuration (PAR_EN, PAR_TYP, Prescale) and applies host writes only between frames, never mid-frame. It tracks frame activity from RX_IN with a timeout, counting frames that end without Data_valid. Received bytes go into a small FIFO drained over a ready/valid interface.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, range 2..16.
DEF_PRESCALE, 8, Prescale value driven after reset; must be a legal value.
ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
CLK  in  1  system clock.
RST  in  1  reset; asynchronous, active-high.
cfg_wr  in  1  single-cycle configuration write strobe.
cfg_par_en  in  1  requested parity enable.
cfg_par_typ  in  1  requested parity type (0 even, 1 odd).
cfg_prescale  in  5  requested oversampling factor; legal values are 8, 16 and 32.
cfg_err  out  1  1-cycle pulse: the write was rejected because the prescale value is illegal.
cfg_pend  out  1  a configuration is accepted but not yet applied.
RX_IN  in  1  serial line, monitored in parallel with the RX datapath; asynchronous to CLK.
rx_p_data  in  8  P_DATA from the RX datapath.
rx_data_valid  in  1  Data_valid pulse from the RX datapath.
PAR_EN  out  1  to the RX datapath.
PAR_TYP  out  1  to the RX datapath.
Prescale  out  5  to the RX datapath.
busy  out  1  a frame is in progress.
out_data  out  8  FIFO head byte.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accepts out_data.
ovf  out  1  sticky: a byte was dropped because the FIFO was full.
ovf_clr  in  1  clears ovf.
err_cnt  out  ERR_CNT_W  count of frames that timed out; saturates at its maximum.

Behaviour:
- Reset values: PAR_EN=0, PAR_TYP=0, Prescale=DEF_PRESCALE, busy=0, cfg_pend=0, cfg_err=0, out_valid=0, out_data=0, ovf=0, err_cnt=0, FSM in IDLE, FIFO empty. Reset asserted mid-frame aborts the frame, discards the FIFO contents and drops any pending configuration.
- RX_IN passes through a 2-flop synchronizer (rx_s). A start edge is rx_s_prev=1 and rx_s=0.
- FSM has two states, IDLE and BUSY:
  - IDLE -> BUSY on a start edge. The timer loads frame_len*Prescale + Prescale/2 − 1, where frame_len = 10 + PAR_EN.
  - BUSY -> IDLE on rx_data_valid, or when the timer reaches 0 (timeout); a timeout increments err_cnt, saturating.
  - rx_data_valid and the timeout in the same cycle count as a good frame; err_cnt does not increment.
  - The timer is 10 bits wide and decrements once per cycle in BUSY.
  - busy=1 exactly while the FSM is in BUSY.
- Configuration:
  - cfg_wr with a legal prescale latches all three fields into shadow registers and sets cfg_pend.
  - cfg_wr with an illegal prescale pulses cfg_err the next cycle; shadow registers and cfg_pend are unchanged.
  - A second write while pending overwrites the shadow (last write wins).
  - Apply happens in IDLE with cfg_pend=1 and no start edge this cycle: the outputs update the next cycle and cfg_pend clears.
  - A start edge takes priority over apply; the pending configuration is applied after the frame ends.
  - cfg_wr in the same cycle as apply: the new write re-pends and the older shadow is applied.
- Data path:
  - rx_data_valid in any state pushes rx_p_data; out_valid rises the cycle after the push (1-cycle latency, no fall-through).
  - Pop occurs when out_valid and out_ready are both 1.
  - Push when full with no pop: the byte is dropped and ovf sets. Push and pop in the same cycle while full: both succeed, no ovf.
  - ovf_clr and an overflow in the same cycle: ovf stays set.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.

Decomposition:
- Package uart_rx_ctrl_pkg holds:
  - the state encoding (IDLE, BUSY);
  - the legal prescale constants 8/16/32;
  - the base frame length constant 10.
- One natural sub-module, uart_rx_fifo: synchronous FIFO with ready/valid output, parameterised by depth and width, with a full flag and a push-dropped flag.

Test Plan:
- Reset, then cfg_wr with prescale=16, par_en=1, typ=1 in IDLE -> cfg_pend for 1 cycle, then Prescale=16, PAR_EN=1, PAR_TYP=1; cfg_pend=0.
- cfg_wr with prescale=12 -> cfg_err pulses 1 cycle; Prescale stays 8; cfg_pend=0.
- Start edge at Prescale=8, then cfg_wr to 32 mid-frame -> Prescale holds 8 until rx_data_valid, is applied the cycle after BUSY->IDLE, and busy drops.
- Start edge with no rx_data_valid at Prescale=8, PAR_EN=0 -> busy holds 84 cycles then clears; err_cnt=1. Repeat 256 times with ERR_CNT_W=8 -> err_cnt saturates at 255.
- out_ready=0, then 5 bytes 0xA1..0xA5 pushed -> FIFO holds A1..A4, ovf=1. Raise out_ready -> A1, A2, A3, A4 in order, then out_valid=0.
- FIFO full, then simultaneous push of 0x55 and pop -> no ovf; 0x55 emerges last. ovf_clr together with an overflowing push -> ovf stays 1.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART RX controller.
package uart_rx_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int unsigned PRESCALE_W     = 5;
   localparam int unsigned TIMER_W        = 10;
   localparam int unsigned DATA_W         = 8;
   localparam int unsigned FRAME_LEN_BASE = 10;

   // An oversampling factor of 32 does not fit the 5-bit field and wraps to 0.
   localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 5'd8;
   localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 5'd16;
   localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 5'd0;

   // True for the three supported oversampling factors.
   function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

   // Decoded oversampling factor (restores 32 from its wrapped encoding).
   function automatic logic [TIMER_W-1:0] prescale_factor(input logic [PRESCALE_W-1:0] p);
      return (p == PRESCALE_32) ? TIMER_W'(32) : TIMER_W'(p);
   endfunction

   // Frame timeout: frame_len * prescale + prescale/2 - 1.
   function automatic logic [TIMER_W-1:0] frame_timeout(input logic                  par_en,
                                                        input logic [PRESCALE_W-1:0] p);
      logic [TIMER_W-1:0] len;
      logic [TIMER_W-1:0] f;
      len = TIMER_W'(FRAME_LEN_BASE) + TIMER_W'(par_en);
      f   = prescale_factor(p);
      return (len * f) + (f >> 1) - TIMER_W'(1);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered ready/valid head and a push-dropped flag.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             drop_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_nxt;
   logic [PW-1:0]    rd_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Push/pop qualification and next-cycle head selection.
   always_comb begin
      full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
      do_pop   = out_valid && pop_ready;
      do_push  = push && (!full || do_pop);
      drop_c   = push && full && !do_pop;
      wr_nxt   = do_push ? wr_ptr + PW'(1) : wr_ptr;
      rd_nxt   = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
      // A byte written into the slot that becomes the head is not in mem yet.
      head_nxt = (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? push_data
                                                                 : mem[rd_nxt[AW-1:0]];
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointers and registered head outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         out_valid <= (wr_nxt != rd_nxt);
         out_data  <= head_nxt;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: frame tracking, between-frame config apply, output FIFO.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned DEF_PRESCALE = 8,
   parameter int unsigned ERR_CNT_W    = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cfg_wr,
   input  logic                  cfg_par_en,
   input  logic                  cfg_par_typ,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   output logic                  cfg_err,
   output logic                  cfg_pend,
   input  logic                  RX_IN,
   input  logic [DATA_W-1:0]     rx_p_data,
   input  logic                  rx_data_valid,
   output logic                  PAR_EN,
   output logic                  PAR_TYP,
   output logic [PRESCALE_W-1:0] Prescale,
   output logic                  busy,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  ovf,
   input  logic                  ovf_clr,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   state_t                  state;
   logic [TIMER_W-1:0]      timer;
   logic                    rx_meta;
   logic                    rx_s;
   logic                    rx_s_prev;
   logic                    start_edge;
   logic                    sh_par_en;
   logic                    sh_par_typ;
   logic [PRESCALE_W-1:0]   sh_prescale;
   logic                    cfg_ok;
   logic                    fifo_drop;

   assign start_edge = rx_s_prev && !rx_s;
   assign cfg_ok     = cfg_wr && prescale_legal(cfg_prescale);

   // Two-flop synchronizer plus edge history; idle line is high.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_s_prev <= 1'b1;
      end else begin
         rx_meta   <= RX_IN;
         rx_s      <= rx_meta;
         rx_s_prev <= rx_s;
      end
   end

   // Frame FSM, timeout counter, config shadow and between-frame apply.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         busy        <= 1'b0;
         timer       <= '0;
         err_cnt     <= '0;
         cfg_err     <= 1'b0;
         cfg_pend    <= 1'b0;
         sh_par_en   <= 1'b0;
         sh_par_typ  <= 1'b0;
         sh_prescale <= PRESCALE_W'(DEF_PRESCALE);
         PAR_EN      <= 1'b0;
         PAR_TYP     <= 1'b0;
         Prescale    <= PRESCALE_W'(DEF_PRESCALE);
      end else begin
         cfg_err <= cfg_wr && !prescale_legal(cfg_prescale);

         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  timer <= frame_timeout(PAR_EN, Prescale);
               end else if (cfg_pend) begin
                  PAR_EN   <= sh_par_en;
                  PAR_TYP  <= sh_par_typ;
                  Prescale <= sh_prescale;
                  cfg_pend <= 1'b0;
               end
            end
            BUSY: begin
               if (rx_data_valid) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (timer == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                     err_cnt <= err_cnt + ERR_CNT_W'(1);
                  end
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end
         endcase

         // A new legal write always re-pends, overriding a same-cycle apply.
         if (cfg_ok) begin
            sh_par_en   <= cfg_par_en;
            sh_par_typ  <= cfg_par_typ;
            sh_prescale <= cfg_prescale;
            cfg_pend    <= 1'b1;
         end
      end
   end

   // Sticky overflow flag; a same-cycle drop wins over clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ovf <= 1'b0;
      end else if (fifo_drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (rx_data_valid),
      .push_data (rx_p_data),
      .pop_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .drop_c    (fifo_drop)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with directed stimulus.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       cfg_wr;
   logic       cfg_par_en;
   logic       cfg_par_typ;
   logic [4:0] cfg_prescale;
   logic       cfg_err;
   logic       cfg_pend;
   logic       RX_IN;
   logic [7:0] rx_p_data;
   logic       rx_data_valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [4:0] Prescale;
   logic       busy;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       ovf;
   logic       ovf_clr;
   logic [7:0] err_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   uart_rx_ctrl #(
      .FIFO_DEPTH   (4),
      .DEF_PRESCALE (8),
      .ERR_CNT_W    (8)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .cfg_wr        (cfg_wr),
      .cfg_par_en    (cfg_par_en),
      .cfg_par_typ   (cfg_par_typ),
      .cfg_prescale  (cfg_prescale),
      .cfg_err       (cfg_err),
      .cfg_pend      (cfg_pend),
      .RX_IN         (RX_IN),
      .rx_p_data     (rx_p_data),
      .rx_data_valid (rx_data_valid),
      .PAR_EN        (PAR_EN),
      .PAR_TYP       (PAR_TYP),
      .Prescale      (Prescale),
      .busy          (busy),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .ovf           (ovf),
      .ovf_clr       (ovf_clr),
      .err_cnt       (err_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic cfg_write(input logic pe, input logic pt, input logic [4:0] ps);
      cfg_par_en   = pe;
      cfg_par_typ  = pt;
      cfg_prescale = ps;
      cfg_wr       = 1'b1;
      tick();
      cfg_wr       = 1'b0;
   endtask

   // Falling pulse on RX_IN, then wait (bounded) until busy rises.
   task automatic start_frame(output logic seen);
      int w;
      RX_IN = 1'b0;
      tick();
      RX_IN = 1'b1;
      w = 0;
      while (!busy && w < 10) begin
         tick();
         w++;
      end
      seen = busy;
   endtask

   // Runs one frame with no data_valid and returns the busy duration.
   task automatic timeout_frame(output int busy_cycles);
      logic seen;
      busy_cycles = 0;
      start_frame(seen);
      if (seen) begin
         while (busy && busy_cycles < 1000) begin
            busy_cycles++;
            tick();
         end
      end
      tick(2);
   endtask

   // Monitor: every accepted output byte is compared with the scoreboard head.
   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fifo_out: got 0x%0h, expected no byte", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               n_fail++;
               $display("FAIL fifo_out: got 0x%0h, expected 0x%0h", out_data, mon_exp);
            end
         end
      end
   end

   initial begin
      int   bc;
      int   w;
      logic seen;

      RST = 1'b1;
      cfg_wr = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_prescale = 5'd8;
      RX_IN = 1'b1; rx_p_data = 8'h00; rx_data_valid = 1'b0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      tick(2);

      check("rst_par_en",    32'(PAR_EN),    32'd0);
      check("rst_par_typ",   32'(PAR_TYP),   32'd0);
      check("rst_prescale",  32'(Prescale),  32'd8);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_cfg_pend",  32'(cfg_pend),  32'd0);
      check("rst_cfg_err",   32'(cfg_err),   32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      check("rst_err_cnt",   32'(err_cnt),   32'd0);
      RST = 1'b0;
      tick();

      // Legal write in IDLE: pend one cycle, then apply.
      cfg_write(1'b1, 1'b1, 5'd16);
      check("cfg_pend_set",     32'(cfg_pend), 32'd1);
      check("cfg_not_yet",      32'(Prescale), 32'd8);
      check("cfg_err_legal",    32'(cfg_err),  32'd0);
      tick();
      check("cfg_apply_ps",     32'(Prescale), 32'd16);
      check("cfg_apply_pe",     32'(PAR_EN),   32'd1);
      check("cfg_apply_pt",     32'(PAR_TYP),  32'd1);
      check("cfg_pend_clr",     32'(cfg_pend), 32'd0);
      cfg_write(1'b0, 1'b0, 5'd8);
      tick();
      check("cfg_restore",      32'(Prescale), 32'd8);

      // Illegal prescale: one-cycle error pulse, nothing pended.
      cfg_write(1'b1, 1'b0, 5'd12);
      check("cfg_err_pulse",    32'(cfg_err),  32'd1);
      check("cfg_err_no_pend",  32'(cfg_pend), 32'd0);
      tick();
      check("cfg_err_gone",     32'(cfg_err),  32'd0);
      check("cfg_err_ps_keep",  32'(Prescale), 32'd8);
      check("cfg_err_pe_keep",  32'(PAR_EN),   32'd0);

      // Mid-frame write of 32 (encoded 0) waits for the frame to end.
      start_frame(seen);
      check("mid_busy",         32'(seen),     32'd1);
      cfg_write(1'b0, 1'b0, 5'd0);
      check("mid_pend",         32'(cfg_pend), 32'd1);
      check("mid_hold",         32'(Prescale), 32'd8);
      tick(5);
      check("mid_hold2",        32'(Prescale), 32'd8);
      out_ready = 1'b1;
      rx_p_data = 8'h3C; rx_data_valid = 1'b1; exp_q.push_back(8'h3C);
      tick();
      rx_data_valid = 1'b0;
      check("mid_busy_drop",    32'(busy),     32'd0);
      check("mid_hold3",        32'(Prescale), 32'd8);
      tick();
      check("mid_apply",        32'(Prescale), 32'd0);
      check("mid_pend_clr",     32'(cfg_pend), 32'd0);
      cfg_write(1'b0, 1'b0, 5'd8);
      tick(2);

      // Timeout at prescale 8 without parity: 84 busy cycles.
      timeout_frame(bc);
      check("to_busy_len",      32'(bc),       32'd84);
      check("to_err_cnt1",      32'(err_cnt),  32'd1);

      // data_valid coinciding with timer expiry counts as good.
      start_frame(seen);
      tick(83);
      rx_p_data = 8'h5A; rx_data_valid = 1'b1; exp_q.push_back(8'h5A);
      tick();
      rx_data_valid = 1'b0;
      check("tie_busy",         32'(busy),     32'd0);
      check("tie_err_cnt",      32'(err_cnt),  32'd1);
      tick(3);

      // Timeout with parity at prescale 16: 11*16+8 = 184 busy cycles.
      cfg_write(1'b1, 1'b0, 5'd16);
      tick();
      timeout_frame(bc);
      check("to16_busy_len",    32'(bc),       32'd184);
      check("to16_err_cnt",     32'(err_cnt),  32'd2);
      cfg_write(1'b0, 1'b0, 5'd8);
      tick();

      // Saturation: 255 timeouts reach the max, the 256th holds it.
      for (int i = 0; i < 253; i++) begin
         timeout_frame(bc);
      end
      check("sat_reach",        32'(err_cnt),  32'd255);
      timeout_frame(bc);
      check("sat_hold",         32'(err_cnt),  32'd255);
      check("sat_busy_len",     32'(bc),       32'd84);

      // FIFO overflow: five pushes into four entries.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_p_data = 8'hA1 + 8'(i);
         rx_data_valid = 1'b1;
         if (i < 4) exp_q.push_back(rx_p_data);
         tick();
      end
      rx_data_valid = 1'b0;
      check("ovf_set",          32'(ovf),       32'd1);
      check("full_valid",       32'(out_valid), 32'd1);
      check("full_head",        32'(out_data),  32'hA1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr",          32'(ovf),       32'd0);

      // Push and pop together while full: no drop.
      out_ready = 1'b1;
      rx_p_data = 8'h55; rx_data_valid = 1'b1; exp_q.push_back(8'h55);
      tick();
      out_ready = 1'b0; rx_data_valid = 1'b0;
      check("full_pushpop_ovf", 32'(ovf),       32'd0);

      // Overflow again, then clear together with another overflow.
      rx_p_data = 8'h66; rx_data_valid = 1'b1;
      tick();
      check("ovf_set2",         32'(ovf),       32'd1);
      rx_p_data = 8'h77; ovf_clr = 1'b1;
      tick();
      rx_data_valid = 1'b0; ovf_clr = 1'b0;
      check("ovf_clr_vs_set",   32'(ovf),       32'd1);

      // Drain: A2, A3, A4, 55 in order, then empty.
      out_ready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         tick();
         w++;
      end
      check("drain_done",       32'(exp_q.size()), 32'd0);
      tick();
      check("drain_empty",      32'(out_valid), 32'd0);

      // Reset mid-frame discards frame, FIFO contents and pending config.
      out_ready = 1'b0;
      rx_p_data = 8'h99; rx_data_valid = 1'b1;
      tick();
      rx_data_valid = 1'b0;
      start_frame(seen);
      cfg_write(1'b1, 1'b1, 5'd16);
      check("pre_rst_busy",     32'(busy),      32'd1);
      check("pre_rst_valid",    32'(out_valid), 32'd1);
      RST = 1'b1;
      #1;
      check("arst_busy",        32'(busy),      32'd0);
      check("arst_valid",       32'(out_valid), 32'd0);
      check("arst_pend",        32'(cfg_pend),  32'd0);
      check("arst_err_cnt",     32'(err_cnt),   32'd0);
      tick();
      RST = 1'b0;
      out_ready = 1'b1;
      tick(3);
      check("post_rst_ps",      32'(Prescale),  32'd8);
      check("post_rst_pe",      32'(PAR_EN),    32'd0);
      check("post_rst_valid",   32'(out_valid), 32'd0);
      check("post_rst_busy",    32'(busy),      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
